// File: rtl/sram_controller.sv
// Cache-side block port to 256Kx16 async SRAM: 64-bit reads as four halfword
// slots, 32-bit writes as two. Optional SRAM_RANGE_CHECK_EN rejects eff >= 512 KiB.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        wrEn,
    input  logic        rdEn,
    output logic [63:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [17:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic [17:0] addr_q, addr_d;
    logic        we_n_q, we_n_d;
    logic        dq_oe_q, dq_oe_d;
    logic [15:0] dq_out_q, dq_out_d;

    logic [31:0] eff;
    logic [17:0] rd_base, wr_base;
    logic        out_of_range;
    logic        unused_eff;

    assign eff     = address - BASE_ADDR;
    assign rd_base = {eff[18:3], 2'b00};
    assign wr_base = {eff[18:2], 1'b0};
    assign unused_eff = ^{eff[31:19], eff[1:0]};

`ifdef SRAM_RANGE_CHECK_EN
    assign out_of_range = |eff[31:19];
`else
    assign out_of_range = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            cnt_q    <= '0;
            base_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            we_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
            dq_out_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            we_n_q   <= we_n_d;
            dq_oe_q  <= dq_oe_d;
            dq_out_q <= dq_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                k_d   = '0;
                cnt_d = '0;
                if (wrEn || rdEn) begin
                    if (out_of_range) begin
                        // Rejected request: complete immediately, no SRAM cycle
                        state_d = DONE;
                        if (!wrEn) rdata_d = '0;
                    end else begin
                        state_d = wrEn ? WRITE : READ;
                        base_d  = wrEn ? wr_base : rd_base;
                        wdata_d = writeData;
                    end
                end
            end
            READ, WRITE: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    k_d   = k_q + 2'd1;
                    if (state_q == READ) rdata_d[{k_q, 4'b0000} +: 16] = SRAM_DQ;
                    if ((state_q == READ && k_q == 2'd3) || (state_q == WRITE && k_q == 2'd1)) begin
                        state_d = DONE;
                        k_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin drivers are registered from next state so they change only on clock edges;
    // WE_N releases on the last cycle of each slot to give address/data hold.
    always_comb begin
        addr_d   = base_d + {16'd0, k_d};
        we_n_d   = !(state_d == WRITE && cnt_d != LAST_CNT);
        dq_oe_d  = (state_d == WRITE);
        dq_out_d = k_d[0] ? wdata_d[31:16] : wdata_d[15:0];
    end

    assign ready     = (state_q == IDLE && !wrEn && !rdEn) || (state_q == DONE);
    assign readData  = rdata_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule
